// File: rtl/mul_seq32.sv
// Unsigned WIDTHxWIDTH -> 2*WIDTH shift-and-add multiplier, one iteration per clock.
// Uses an external combinational adder: drives add_a/add_b, consumes add_res/add_cout.
module mul_seq32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_res,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 load;
  logic                 last_iter;

  // Operands are accepted only outside RUN; start during RUN is ignored.
  assign load      = start && (state_q != S_RUN);
  assign last_iter = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last_iter) state_d = S_DONE;
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: all derived from registered state only
  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    product = product_q;
    add_a   = hi_q;
    add_b   = lo_q[0] ? mcand_q : '0;
  end

  // Datapath next-state. The 65-bit {cout, sum, lo} >> 1 is written out per
  // register so the carry lands in hi[WIDTH-1] and sum[0] in lo[WIDTH-1].
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (load) begin
      mcand_d = op_a;
      lo_d    = op_b;
      hi_d    = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      hi_d  = {add_cout, add_res[WIDTH-1:1]};
      lo_d  = {add_res[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        product_d = {hi_d, lo_d};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule
